// File: rtl/log2_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | log2_seq_ctrl: sequential fixed-point log2 via normalise-then-square.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module log2_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int OUT_FRAC = 16,
  parameter int KW       = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x_in,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [WIDTH-1:0]     mul_r,
  input  logic                 mul_ovf,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic signed [KW-1:0] log_int,
  output logic [OUT_FRAC-1:0]  log_frac
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_NORM   = 2'd1;
  localparam logic [1:0] S_SQUARE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int CW = $clog2(OUT_FRAC + 1);

  localparam logic [WIDTH-1:0]     C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [WIDTH-1:0]     C_TWO      = {{(WIDTH-1){1'b0}}, 1'b1} << (FRAC + 1);
  localparam logic signed [KW-1:0] C_K_ONE    = KW'(1);
  localparam logic [CW-1:0]        C_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]        C_CNT_LAST = CW'(OUT_FRAC - 1);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic signed [KW-1:0] k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_FRAC-1:0]  frac_q, frac_d;
  logic                 err_q, err_d;

  logic                 w_sq_ge2;

  // Squared value is below 4.0 because y stays in [1,2) during SQUARE.
  assign w_sq_ge2 = (mul_r >= C_TWO);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    frac_d  = frac_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          y_d    = x_in;
          k_d    = '0;
          cnt_d  = '0;
          frac_d = '0;
          if (x_in == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_NORM;
          end
        end
      end

      S_NORM: begin
        if (y_q >= C_TWO) begin
          y_d = y_q >> 1;
          k_d = k_q + C_K_ONE;
        end else if (y_q < C_ONE) begin
          y_d = y_q << 1;
          k_d = k_q - C_K_ONE;
        end else begin
          state_d = S_SQUARE;
        end
      end

      S_SQUARE: begin
        frac_d = {frac_q[OUT_FRAC-2:0], w_sq_ge2};
        y_d    = w_sq_ge2 ? (mul_r >> 1) : mul_r;
        cnt_d  = cnt_q + C_CNT_ONE;
        if (mul_ovf) begin
          err_d = 1'b1;
        end
        if (cnt_q == C_CNT_LAST) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      frac_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      frac_q  <= frac_d;
      err_q   <= err_d;
    end
  end

  // The external multiplier is always used as a squarer.
  assign mul_a    = y_q;
  assign mul_b    = y_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign log_int  = k_q;
  assign log_frac = frac_q;

endmodule
`default_nettype wire

// File: tb/tb_log2_seq_ctrl.sv
`default_nettype none
// Scoreboarded bench for log2_seq_ctrl with a behavioural squaring multiplier.
module tb_log2_seq_ctrl;
  localparam int WIDTH    = 32;
  localparam int FRAC     = 16;
  localparam int OUT_FRAC = 16;
  localparam int KW       = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [WIDTH-1:0]     x_in;
  logic [WIDTH-1:0]     mul_a, mul_b, mul_r;
  logic                 mul_ovf;
  logic                 busy, done, err;
  logic signed [KW-1:0] log_int;
  logic [OUT_FRAC-1:0]  log_frac;
  logic                 force_ovf;
  logic [63:0]          prod;

  always #5 clk = ~clk;

  log2_seq_ctrl #(.WIDTH(WIDTH), .FRAC(FRAC), .OUT_FRAC(OUT_FRAC), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in),
    .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r), .mul_ovf(mul_ovf),
    .busy(busy), .done(done), .err(err), .log_int(log_int), .log_frac(log_frac)
  );

  // Fixed-point multiplier: Q16.16 product, truncated, overflow on lost upper bits.
  assign prod    = {32'd0, mul_a} * {32'd0, mul_b};
  assign mul_r   = prod[47:16];
  assign mul_ovf = (|prod[63:48]) | force_ovf;

  typedef struct {
    int          k;
    logic [15:0] f;
    bit          e;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   after_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference: floor(log2) from the leading one, then 16 truncated squarings of y in [1,2).
  function automatic void model(input logic [31:0] x, output int k, output logic [15:0] f,
                                output bit e, output int lat);
    longint unsigned y, s;
    int p;
    k = 0; f = '0; e = 1'b0; lat = 1;
    if (x == 0) begin
      e = 1'b1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    k = p - FRAC;
    y = (k >= 0) ? (64'(x) >> k) : (64'(x) << (-k));
    for (int i = 0; i < OUT_FRAC; i++) begin
      s = (y * y) >> FRAC;
      f = {f[14:0], (s >= 64'h2_0000)};
      y = (s >= 64'h2_0000) ? (s >> 1) : s;
    end
    lat = ((k < 0) ? -k : k) + 2 + OUT_FRAC;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      after_done = 1'b0;
    end else begin
      chk("mul_a_eq_mul_b", mul_a, mul_b);
      if (after_done) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        after_done = 1'b0;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          m_e = q.pop_front();
          chk("log_int", log_int, m_e.k);
          chk("log_frac", log_frac, m_e.f);
          chk("err", err, m_e.e);
          chk("latency", cyc - m_e.acc + 1, m_e.lat);
          chk("busy_in_done", busy, 1);
        end
        after_done = 1'b1;
      end
    end
  end

  // Issues one operation; poke_j/ovf_j are cycle offsets after the accepting edge (-1 = none).
  task automatic run_op(input logic [31:0] x, input exp_t ex, input int poke_j,
                        input int ovf_j, input bit done_poke);
    int j;
    @(posedge clk); #1;
    start = 1'b1;
    x_in  = x;
    @(posedge clk); #1;
    start = 1'b0;
    x_in  = $urandom;
    ex.acc = cyc;
    q.push_back(ex);
    for (j = 0; j < 300; j++) begin
      if (j == poke_j) begin
        start = 1'b1;
        x_in  = $urandom;
      end
      if (j == ovf_j) force_ovf = 1'b1;
      if (done_poke && j == ex.lat - 1) start = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      force_ovf = 1'b0;
      if (!busy) break;
    end
    chk("op_terminates", (j < 300), 1);
    if (done_poke) begin
      @(posedge clk); #1;
      chk("start_in_done_ignored", busy, 0);
    end
  endtask

  task automatic run_model(input logic [31:0] x, input bit poke, input bit ovf, input bit done_poke);
    exp_t ex;
    int   n, pj, oj;
    model(x, ex.k, ex.f, ex.e, ex.lat);
    n  = (ex.k < 0) ? -ex.k : ex.k;
    pj = -1;
    oj = -1;
    if (x != 0) begin
      if (poke) pj = n + 1 + $urandom_range(0, OUT_FRAC - 1);
      if (ovf) begin
        oj   = n + 1 + $urandom_range(0, OUT_FRAC - 1);
        ex.e = 1'b1;
      end
    end
    ex.acc = 0;
    run_op(x, ex, pj, oj, done_poke);
  endtask

  function automatic exp_t mk(input int k, input logic [15:0] f, input bit e, input int lat);
    exp_t ex;
    ex.k = k; ex.f = f; ex.e = e; ex.lat = lat; ex.acc = 0;
    return ex;
  endfunction

  initial begin
    int diff;
    rst       = 1'b1;
    start     = 1'b0;
    x_in      = '0;
    force_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_log_int", log_int, 0);
    chk("reset_log_frac", log_frac, 0);
    chk("reset_mul_a", mul_a, 0);

    run_op(32'h0001_0000, mk(0, 16'h0000, 1'b0, 18), -1, -1, 1'b0);
    run_model(32'h0001_E000, 1'b0, 1'b0, 1'b0);
    diff = int'(log_frac) - 16'hE829;
    chk("frac_1p875_within_1lsb", ((diff <= 1) && (diff >= -1)), 1);
    chk("held_log_int_1p875", log_int, 0);
    run_op(32'h0000_8000, mk(-1, 16'h0000, 1'b0, 19), -1, -1, 1'b0);
    run_op(32'h0040_0000, mk(6, 16'h0000, 1'b0, 24), -1, -1, 1'b0);
    run_op(32'h0000_0000, mk(0, 16'h0000, 1'b1, 1), -1, -1, 1'b0);
    run_op(32'h0000_0001, mk(-16, 16'h0000, 1'b0, 34), -1, -1, 1'b0);
    run_op(32'h0001_0000, mk(0, 16'h0000, 1'b0, 18), 6, -1, 1'b0);
    run_op(32'h0001_0000, mk(0, 16'h0000, 1'b1, 18), -1, 9, 1'b0);
    run_model(32'h0001_E000, 1'b0, 1'b0, 1'b1);
    run_op(32'h0001_0000, mk(0, 16'h0000, 1'b0, 18), -1, -1, 1'b0);

    // Abort mid-SQUARE with err already set and partial fraction bits present.
    @(posedge clk); #1;
    start = 1'b1;
    x_in  = 32'h0001_E000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 force_ovf = 1'b1;
    @(posedge clk); #1;
    force_ovf = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_log_int", log_int, 0);
    chk("abort_log_frac", log_frac, 0);
    chk("abort_mul_a", mul_a, 0);
    run_op(32'h0001_0000, mk(0, 16'h0000, 1'b0, 18), -1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x;
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) x = '0;
      run_model(x, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
